// File: rtl/resp_router_pkg.sv
// Shared vector constants for the response path and the request arbiter.
// The router and its per-core buffers size themselves from these defaults.
package resp_router_pkg;

  localparam int DEF_NUM_OF_CORES = 4;
  localparam int ARB_NUM_CORES    = DEF_NUM_OF_CORES;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_RESP_DEPTH   = 4;
  localparam int CORE_ID_W        = (DEF_NUM_OF_CORES > 1) ? $clog2(DEF_NUM_OF_CORES) : 1;

  // Pointer/occupancy width: one extra bit separates full from empty.
  function automatic int resp_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Core id width that stays legal for a single-core build.
  function automatic int core_id_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Single per-core response buffer: register storage, wrap-bit pointers,
// occupancy, full and empty flags.
module resp_fifo
  import resp_router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_RESP_DEPTH,
  localparam int PTR_W     = resp_ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PTR_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Status flags from the pointer pair; push/pop are guarded against full/empty.
  always_comb begin
    full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    empty     = (wr_ptr_r == rd_ptr_r);
    count     = wr_ptr_r - rd_ptr_r;
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    head_data = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read/write pointers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Payload storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/resp_router.sv
// Routes memory responses to per-core FIFOs by core id; each core drains
// its own buffer independently with a valid/ready handshake.
module resp_router
  import resp_router_pkg::*;
#(
  parameter int NUM_OF_CORES = DEF_NUM_OF_CORES,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RESP_DEPTH   = DEF_RESP_DEPTH,
  localparam int CID_W       = core_id_w(NUM_OF_CORES),
  localparam int CNT_W       = resp_ptr_w(RESP_DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               mem_resp_valid,
  input  logic [CID_W-1:0]                   mem_resp_core_id,
  input  logic [DATA_WIDTH-1:0]              mem_resp_data,
  output logic                               mem_resp_ready,
  output logic [NUM_OF_CORES-1:0]            core_resp_valid,
  output logic [NUM_OF_CORES*DATA_WIDTH-1:0] core_resp_data,
  input  logic [NUM_OF_CORES-1:0]            core_resp_ready,
  output logic [NUM_OF_CORES*CNT_W-1:0]      core_resp_count
);

  logic [NUM_OF_CORES-1:0] full_s;
  logic [NUM_OF_CORES-1:0] empty_s;
  logic [NUM_OF_CORES-1:0] push_s;
  logic [NUM_OF_CORES-1:0] pop_s;
  logic [(2**CID_W)-1:0]   full_ext_s;

  // Ready mux: ids with no core behind them read as full and are never accepted.
  always_comb begin
    full_ext_s = {(2**CID_W){1'b1}};
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      full_ext_s[i] = full_s[i];
    end
    mem_resp_ready = ~full_ext_s[mem_resp_core_id];
  end

  // One-hot push decode and handshake-qualified pops.
  always_comb begin
    core_resp_valid = ~empty_s;
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      push_s[i] = mem_resp_valid & mem_resp_ready & (mem_resp_core_id == CID_W'(i));
      pop_s[i]  = core_resp_ready[i] & core_resp_valid[i];
    end
  end

  for (genvar g = 0; g < NUM_OF_CORES; g++) begin : g_core
    resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_s[g]),
      .push_data (mem_resp_data),
      .pop       (pop_s[g]),
      .head_data (core_resp_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .count     (core_resp_count[g*CNT_W +: CNT_W]),
      .full      (full_s[g]),
      .empty     (empty_s[g])
    );
  end

endmodule

// File: tb/tb_resp_router.sv
// Self-checking bench for resp_router: directed scenarios plus a randomized
// run against a per-core queue model of the routing rules.
module tb_resp_router;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int D  = 4;
  localparam int CW = 3;

  logic             clk;
  logic             reset_n;
  logic             mem_resp_valid;
  logic [1:0]       mem_resp_core_id;
  logic [DW-1:0]    mem_resp_data;
  logic             mem_resp_ready;
  logic [NC-1:0]    core_resp_valid;
  logic [NC*DW-1:0] core_resp_data;
  logic [NC-1:0]    core_resp_ready;
  logic [NC*CW-1:0] core_resp_count;

  logic [DW-1:0] mq [NC][$];
  int n_cmp;
  int n_fail;

  resp_router dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_core_id (mem_resp_core_id),
    .mem_resp_data    (mem_resp_data),
    .mem_resp_ready   (mem_resp_ready),
    .core_resp_valid  (core_resp_valid),
    .core_resp_data   (core_resp_data),
    .core_resp_ready  (core_resp_ready),
    .core_resp_count  (core_resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] id, input logic [DW-1:0] d,
                       input logic [NC-1:0] rdy);
    mem_resp_valid   = v;
    mem_resp_core_id = id;
    mem_resp_data    = d;
    core_resp_ready  = rdy;
    #1;
  endtask

  // Advance one clock and apply the FIFO-per-core rules to the model.
  task automatic tick();
    logic          acc;
    logic [1:0]    id;
    logic [DW-1:0] d;
    logic [NC-1:0] pp;
    id  = mem_resp_core_id;
    d   = mem_resp_data;
    acc = reset_n && mem_resp_valid && (mq[id].size() < D);
    for (int i = 0; i < NC; i++) pp[i] = reset_n && core_resp_ready[i] && (mq[i].size() > 0);
    @(posedge clk);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < NC; i++) if (pp[i]) void'(mq[i].pop_front());
      if (acc) mq[id].push_back(d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (core_resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0000", core_resp_valid);
    end
    n_cmp++;
    if (mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", mem_resp_ready);
    end
    n_cmp++;
    if (core_resp_count !== 12'd0) begin
      n_fail++; $display("FAIL reset_count: got %h want 000", core_resp_count);
    end
  endtask

  task automatic test_single_route();
    drive(1'b1, 2'd2, 64'hA5, 4'b0000);
    n_cmp++;
    if (mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b want 1", mem_resp_ready);
    end
    n_cmp++;
    if (core_resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_bypass: got %b want 0000", core_resp_valid);
    end
    tick();
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    n_cmp++;
    if (core_resp_valid !== 4'b0100) begin
      n_fail++; $display("FAIL single_valid: got %b want 0100", core_resp_valid);
    end
    n_cmp++;
    if (core_resp_data[2*DW +: DW] !== 64'hA5) begin
      n_fail++; $display("FAIL single_data: got %h want a5", core_resp_data[2*DW +: DW]);
    end
    n_cmp++;
    if (core_resp_count[2*CW +: CW] !== 3'd1) begin
      n_fail++; $display("FAIL single_count: got %0d want 1", core_resp_count[2*CW +: CW]);
    end
    drive(1'b0, 2'd0, 64'd0, 4'b0100);
    tick();
    n_cmp++;
    if (core_resp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_drain: got %b want 0000", core_resp_valid);
    end
  endtask

  task automatic test_fill_full();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd1, 64'(k), 4'b0000);
      tick();
    end
    drive(1'b0, 2'd1, 64'd0, 4'b0000);
    n_cmp++;
    if (core_resp_count[1*CW +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL fill_count: got %0d want 4", core_resp_count[1*CW +: CW]);
    end
    n_cmp++;
    if (mem_resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_ready_id1: got %b want 0", mem_resp_ready);
    end
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    n_cmp++;
    if (mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_ready_id0: got %b want 1", mem_resp_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 2'd0, 64'd0, 4'b0010);
      n_cmp++;
      if (core_resp_valid[1] !== 1'b1 || core_resp_data[1*DW +: DW] !== 64'(k)) begin
        n_fail++;
        $display("FAIL fill_drain: got v=%b d=%0d want v=1 d=%0d",
                 core_resp_valid[1], core_resp_data[1*DW +: DW], k);
      end
      tick();
    end
    n_cmp++;
    if (core_resp_count[1*CW +: CW] !== 3'd0) begin
      n_fail++; $display("FAIL fill_empty: got %0d want 0", core_resp_count[1*CW +: CW]);
    end
  endtask

  task automatic test_full_concurrent_pop();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd3, {$urandom, $urandom}, 4'b0000);
      tick();
    end
    drive(1'b1, 2'd3, 64'hDEAD, 4'b1000);
    n_cmp++;
    if (mem_resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_ready: got %b want 0", mem_resp_ready);
    end
    tick();
    n_cmp++;
    if (core_resp_count[3*CW +: CW] !== 3'd3) begin
      n_fail++; $display("FAIL fullpop_count: got %0d want 3", core_resp_count[3*CW +: CW]);
    end
    drive(1'b1, 2'd3, 64'hBEEF, 4'b0000);
    n_cmp++;
    if (mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL fullpop_ready_next: got %b want 1", mem_resp_ready);
    end
    tick();
    n_cmp++;
    if (core_resp_count[3*CW +: CW] !== 3'd4) begin
      n_fail++; $display("FAIL fullpop_refill: got %0d want 4", core_resp_count[3*CW +: CW]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'd0, 64'd0, 4'b1000);
      n_cmp++;
      if (core_resp_data[3*DW +: DW] !== mq[3][0]) begin
        n_fail++; $display("FAIL fullpop_order: got %h want %h", core_resp_data[3*DW +: DW], mq[3][0]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) begin
      drive(k < 10, 2'd0, {$urandom, $urandom}, {3'b000, (k % 3) != 0});
      n_cmp++;
      if (core_resp_count[0 +: CW] > 3'd4 || core_resp_count[0 +: CW] !== 3'(mq[0].size())) begin
        n_fail++; $display("FAIL wrap_count: got %0d want %0d", core_resp_count[0 +: CW], mq[0].size());
      end
      if (mq[0].size() > 0) begin
        n_cmp++;
        if (core_resp_data[0 +: DW] !== mq[0][0]) begin
          n_fail++; $display("FAIL wrap_data: got %h want %h", core_resp_data[0 +: DW], mq[0][0]);
        end
      end
      tick();
    end
    drive(1'b0, 2'd0, 64'd0, 4'b0001);
    repeat (6) tick();
    n_cmp++;
    if (core_resp_count[0 +: CW] !== 3'd0) begin
      n_fail++; $display("FAIL wrap_empty: got %0d want 0", core_resp_count[0 +: CW]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k < 2) ? 2'd0 : 2'd2, 64'h100 + 64'(k), 4'b0000);
      tick();
    end
    drive(1'b1, 2'd0, 64'h777, 4'b1111);
    reset_n = 1'b0;
    for (int i = 0; i < NC; i++) mq[i].delete();
    #1;
    n_cmp++;
    if (core_resp_valid !== 4'b0000 || core_resp_count !== 12'd0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b c=%h want v=0000 c=000", core_resp_valid, core_resp_count);
    end
    tick();
    reset_n = 1'b1;
    drive(1'b1, 2'd0, 64'h5555, 4'b0000);
    tick();
    drive(1'b0, 2'd0, 64'd0, 4'b0000);
    n_cmp++;
    if (core_resp_count[0 +: CW] !== 3'd1 || core_resp_data[0 +: DW] !== 64'h5555) begin
      n_fail++;
      $display("FAIL midrst_new: got c=%0d d=%h want c=1 d=5555", core_resp_count[0 +: CW], core_resp_data[0 +: DW]);
    end
    n_cmp++;
    if (core_resp_valid !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_valid: got %b want 0001", core_resp_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            4'($urandom & $urandom));
      n_cmp++;
      if (mem_resp_ready !== (mq[mem_resp_core_id].size() < D)) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, mem_resp_ready,
                           mq[mem_resp_core_id].size() < D);
      end
      for (int i = 0; i < NC; i++) begin
        n_cmp++;
        if (core_resp_count[i*CW +: CW] !== 3'(mq[i].size()) ||
            core_resp_valid[i] !== (mq[i].size() != 0)) begin
          n_fail++; $display("FAIL rnd_state cyc %0d core %0d: got c=%0d v=%b want c=%0d", c, i,
                             core_resp_count[i*CW +: CW], core_resp_valid[i], mq[i].size());
        end
        if (mq[i].size() > 0) begin
          n_cmp++;
          if (core_resp_data[i*DW +: DW] !== mq[i][0]) begin
            n_fail++; $display("FAIL rnd_data cyc %0d core %0d: got %h want %h", c, i,
                               core_resp_data[i*DW +: DW], mq[i][0]);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_route();
    test_fill_full();
    test_full_concurrent_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
